id_ex_operand_stage: RTL and testbench

//   ID->EX pipeline stage of the 5-stage RV32 core. Drives the register-file read addresses, resolves

---
 rtl/id_ex_operand_stage_if.sv | 44 ++++
 rtl/id_ex_operand_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_operand_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX pipeline channel: decoded instruction from ID and the registered
// instruction presented to EX, with their valid/ready handshakes.
interface id_ex_operand_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 16
);
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              id_rs1_en;
    logic              id_rs2_en;
    logic              id_rd_we;
    logic              id_is_load;

    logic              ex_ready;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rd;
    logic              ex_rd_we;
    logic              ex_is_load;

    modport master (
        output id_valid, id_pc, id_imm, id_ctrl, id_rs1, id_rs2, id_rd,
               id_rs1_en, id_rs2_en, id_rd_we, id_is_load, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_ctrl,
               ex_rd, ex_rd_we, ex_is_load
    );

    modport slave (
        input  id_valid, id_pc, id_imm, id_ctrl, id_rs1, id_rs2, id_rd,
               id_rs1_en, id_rs2_en, id_rd_we, id_is_load, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_ctrl,
               ex_rd, ex_rd_we, ex_is_load
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID->EX stage: operand bypass from MEM/WB, load-use / MEM-not-ready hazard
// detection, and the ID/EX register with stall, bubble and flush.
module id_ex_operand_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CTRL_W      = 16,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    id_ex_operand_stage_if.slave   pipe,
    output logic [4:0]             rf_ra0,
    output logic [4:0]             rf_ra1,
    input  logic [XLEN-1:0]        rf_rd0,
    input  logic [XLEN-1:0]        rf_rd1,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_we,
    input  logic [XLEN-1:0]        mem_wd,
    input  logic                   mem_fwd_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_we,
    input  logic [XLEN-1:0]        wb_wd,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    logic              ex_valid_q;
    logic [XLEN-1:0]   ex_pc_q;
    logic [XLEN-1:0]   ex_imm_q;
    logic [XLEN-1:0]   ex_op1_q;
    logic [XLEN-1:0]   ex_op2_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [4:0]        ex_rd_q;
    logic              ex_rd_we_q;
    logic              ex_is_load_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [XLEN-1:0] op1_d;
    logic [XLEN-1:0] op2_d;
    logic            load_in_ex;
    logic            mem_pending;
    logic            rs1_haz;
    logic            rs2_haz;
    logic            hazard;
    logic            advance;
    logic            id_ready;
    logic            stall_inc;

    assign rf_ra0 = pipe.id_rs1;
    assign rf_ra1 = pipe.id_rs2;

    // MEM result is newer than WB, so it takes precedence.
    always_comb begin
        op1_d = rf_rd0;
        if (pipe.id_rs1 == 5'd0)                     op1_d = '0;
        else if (mem_we && mem_rd == pipe.id_rs1)    op1_d = mem_wd;
        else if (wb_we && wb_rd == pipe.id_rs1)      op1_d = wb_wd;

        op2_d = rf_rd1;
        if (pipe.id_rs2 == 5'd0)                     op2_d = '0;
        else if (mem_we && mem_rd == pipe.id_rs2)    op2_d = mem_wd;
        else if (wb_we && wb_rd == pipe.id_rs2)      op2_d = wb_wd;
    end

    assign load_in_ex  = ex_valid_q && ex_rd_we_q && ex_is_load_q;
    assign mem_pending = mem_we && !mem_fwd_valid;

    assign rs1_haz = pipe.id_rs1_en && (pipe.id_rs1 != 5'd0) &&
                     ((load_in_ex && ex_rd_q == pipe.id_rs1) ||
                      (mem_pending && mem_rd == pipe.id_rs1));
    assign rs2_haz = pipe.id_rs2_en && (pipe.id_rs2 != 5'd0) &&
                     ((load_in_ex && ex_rd_q == pipe.id_rs2) ||
                      (mem_pending && mem_rd == pipe.id_rs2));

    assign hazard    = pipe.id_valid && (rs1_haz || rs2_haz);
    assign advance   = !ex_valid_q || pipe.ex_ready;
    assign id_ready  = rstn && (flush || (advance && !hazard));
    assign stall_inc = rstn && pipe.id_valid && !flush && !id_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_imm_q     <= '0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_ctrl_q    <= '0;
            ex_rd_q      <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (advance && hazard) begin
            ex_valid_q <= 1'b0;
        end else if (advance) begin
            ex_valid_q   <= pipe.id_valid;
            ex_pc_q      <= pipe.id_pc;
            ex_imm_q     <= pipe.id_imm;
            ex_op1_q     <= op1_d;
            ex_op2_q     <= op2_d;
            ex_ctrl_q    <= pipe.id_ctrl;
            ex_rd_q      <= pipe.id_rd;
            ex_rd_we_q   <= pipe.id_rd_we;
            ex_is_load_q <= pipe.id_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else if (stall_inc && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign pipe.id_ready   = id_ready;
    assign pipe.ex_valid   = ex_valid_q;
    assign pipe.ex_pc      = ex_pc_q;
    assign pipe.ex_imm     = ex_imm_q;
    assign pipe.ex_op1     = ex_op1_q;
    assign pipe.ex_op2     = ex_op2_q;
    assign pipe.ex_ctrl    = ex_ctrl_q;
    assign pipe.ex_rd      = ex_rd_q;
    assign pipe.ex_rd_we   = ex_rd_we_q;
    assign pipe.ex_is_load = ex_is_load_q;
    assign stall_cnt       = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: bypass vector table plus hand-written
// hazard, back-pressure, flush, reset and counter-saturation sequences.
module tb_id_ex_operand_stage;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             flush;
    logic [4:0]       rf_ra0;
    logic [4:0]       rf_ra1;
    logic [XLEN-1:0]  rf_rd0;
    logic [XLEN-1:0]  rf_rd1;
    logic [4:0]       mem_rd;
    logic             mem_we;
    logic [XLEN-1:0]  mem_wd;
    logic             mem_fwd_valid;
    logic [4:0]       wb_rd;
    logic             wb_we;
    logic [XLEN-1:0]  wb_wd;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_operand_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) pipe ();

    id_ex_operand_stage #(
        .XLEN        (XLEN),
        .CTRL_W      (CTRL_W),
        .STALL_CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush         (flush),
        .pipe          (pipe),
        .rf_ra0        (rf_ra0),
        .rf_ra1        (rf_ra1),
        .rf_rd0        (rf_rd0),
        .rf_rd1        (rf_rd1),
        .mem_rd        (mem_rd),
        .mem_we        (mem_we),
        .mem_wd        (mem_wd),
        .mem_fwd_valid (mem_fwd_valid),
        .wb_rd         (wb_rd),
        .wb_we         (wb_we),
        .wb_wd         (wb_wd),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_en;
        logic        rs2_en;
        logic [31:0] rf0;
        logic [31:0] rf1;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_wd;
        logic        fwd;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_wd;
        logic        exp_ready;
        logic [31:0] exp_op1;
        logic [31:0] exp_op2;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rs1 rs2 e1 e2  rf0    rf1    mwe mrd mwd    fwd wwe wrd wwd    rdy op1    op2
        vecs[0] = '{1,  2,  1, 1,  32'h5,  32'h7,  0, 0, 32'h0,  1,  0,  0, 32'h0,  1, 32'h5,  32'h7};
        vecs[1] = '{1,  2,  1, 1,  32'h11, 32'h7,  1, 1, 32'hAA, 1,  1,  1, 32'hBB, 1, 32'hAA, 32'h7};
        vecs[2] = '{0,  2,  1, 1,  32'h55, 32'h7,  1, 0, 32'hAA, 1,  1,  0, 32'hBB, 1, 32'h0,  32'h7};
        vecs[3] = '{4,  3,  1, 1,  32'h44, 32'h11, 0, 0, 32'h0,  1,  1,  3, 32'hBB, 1, 32'h44, 32'hBB};
        vecs[4] = '{4,  3,  1, 1,  32'h44, 32'h11, 0, 0, 32'h0,  1,  0,  3, 32'hBB, 1, 32'h44, 32'h11};
        vecs[5] = '{4,  2,  1, 1,  32'h44, 32'h7,  1, 2, 32'hCC, 0,  0,  0, 32'h0,  0, 32'h0,  32'h0};
        vecs[6] = '{4,  2,  1, 0,  32'h44, 32'h7,  1, 2, 32'hCC, 0,  0,  0, 32'h0,  1, 32'h44, 32'hCC};
        vecs[7] = '{0,  6,  1, 1,  32'h99, 32'h66, 1, 0, 32'hCC, 0,  0,  0, 32'h0,  1, 32'h0,  32'h66};
        vecs[8] = '{7,  6,  1, 1,  32'h77, 32'h66, 0, 7, 32'hCC, 0,  1,  6, 32'hDD, 1, 32'h77, 32'hDD};

        rstn = 1'b0; flush = 1'b0;
        rf_rd0 = '0; rf_rd1 = '0;
        mem_rd = '0; mem_we = 1'b0; mem_wd = '0; mem_fwd_valid = 1'b1;
        wb_rd = '0; wb_we = 1'b0; wb_wd = '0;
        pipe.id_valid = 1'b1; pipe.id_pc = '0; pipe.id_imm = '0; pipe.id_ctrl = '0;
        pipe.id_rs1 = '0; pipe.id_rs2 = '0; pipe.id_rd = '0;
        pipe.id_rs1_en = 1'b0; pipe.id_rs2_en = 1'b0; pipe.id_rd_we = 1'b0; pipe.id_is_load = 1'b0;
        pipe.ex_ready = 1'b1;

        // Reset state
        step();
        step();
        check("reset_id_ready", 32'(pipe.id_ready), 32'h0);
        check("reset_ex_valid", 32'(pipe.ex_valid), 32'h0);
        check("reset_ex_op1", pipe.ex_op1, 32'h0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
        rstn = 1'b1;

        // Operand resolve / hazard table
        for (int i = 0; i < 9; i++) begin
            pipe.id_rs1 = vecs[i].rs1; pipe.id_rs2 = vecs[i].rs2;
            pipe.id_rs1_en = vecs[i].rs1_en; pipe.id_rs2_en = vecs[i].rs2_en;
            pipe.id_rd = 5'd3; pipe.id_rd_we = 1'b1; pipe.id_is_load = 1'b0;
            pipe.id_pc = 32'h100 + 32'(i * 4); pipe.id_imm = 32'(i);
            pipe.id_ctrl = 16'hA500 + 16'(i);
            rf_rd0 = vecs[i].rf0; rf_rd1 = vecs[i].rf1;
            mem_we = vecs[i].mem_we; mem_rd = vecs[i].mem_rd; mem_wd = vecs[i].mem_wd;
            mem_fwd_valid = vecs[i].fwd;
            wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_wd = vecs[i].wb_wd;
            #1;
            check($sformatf("vec%0d_rf_ra0", i), 32'(rf_ra0), 32'(vecs[i].rs1));
            check($sformatf("vec%0d_rf_ra1", i), 32'(rf_ra1), 32'(vecs[i].rs2));
            check($sformatf("vec%0d_id_ready", i), 32'(pipe.id_ready), 32'(vecs[i].exp_ready));
            step();
            check($sformatf("vec%0d_ex_valid", i), 32'(pipe.ex_valid), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_ready) begin
                check($sformatf("vec%0d_ex_op1", i), pipe.ex_op1, vecs[i].exp_op1);
                check($sformatf("vec%0d_ex_op2", i), pipe.ex_op2, vecs[i].exp_op2);
                check($sformatf("vec%0d_ex_pc", i), pipe.ex_pc, 32'h100 + 32'(i * 4));
                check($sformatf("vec%0d_ex_ctrl", i), 32'(pipe.ex_ctrl), 32'hA500 + 32'(i));
            end
        end
        check("table_stall_cnt", 32'(stall_cnt), 32'h1);

        // Load-use: lw x5 then consumer of x5
        mem_we = 1'b0; wb_we = 1'b0; mem_fwd_valid = 1'b1;
        pipe.id_rs1 = 5'd1; pipe.id_rs1_en = 1'b1; pipe.id_rs2_en = 1'b0;
        pipe.id_rd = 5'd5; pipe.id_rd_we = 1'b1; pipe.id_is_load = 1'b1; pipe.id_pc = 32'h400;
        #1;
        check("lw_id_ready", 32'(pipe.id_ready), 32'h1);
        step();
        check("lw_ex_is_load", 32'(pipe.ex_is_load), 32'h1);
        check("lw_ex_rd", 32'(pipe.ex_rd), 32'h5);
        pipe.id_rs2 = 5'd5; pipe.id_rs2_en = 1'b1; pipe.id_rd = 5'd3;
        pipe.id_is_load = 1'b0; pipe.id_pc = 32'h404;
        #1;
        check("loaduse_id_ready", 32'(pipe.id_ready), 32'h0);
        step();
        check("loaduse_bubble", 32'(pipe.ex_valid), 32'h0);
        check("loaduse_stall_cnt", 32'(stall_cnt), 32'h2);
        mem_we = 1'b1; mem_rd = 5'd5; mem_wd = 32'h1234; mem_fwd_valid = 1'b1;
        #1;
        check("loaduse_fwd_ready", 32'(pipe.id_ready), 32'h1);
        step();
        check("loaduse_ex_valid", 32'(pipe.ex_valid), 32'h1);
        check("loaduse_ex_op2", pipe.ex_op2, 32'h1234);
        check("loaduse_ex_pc", pipe.ex_pc, 32'h404);

        // EX back-pressure for three cycles
        mem_we = 1'b0; pipe.id_pc = 32'h500; pipe.ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_id_ready", k), 32'(pipe.id_ready), 32'h0);
            step();
            check($sformatf("bp%0d_ex_pc", k), pipe.ex_pc, 32'h404);
            check($sformatf("bp%0d_ex_op2", k), pipe.ex_op2, 32'h1234);
        end
        check("bp_stall_cnt", 32'(stall_cnt), 32'h5);
        pipe.ex_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(pipe.id_ready), 32'h1);
        step();
        check("bp_release_ex_pc", pipe.ex_pc, 32'h500);

        // Flush, then flush together with a hazard
        flush = 1'b1; pipe.id_pc = 32'h600;
        #1;
        check("flush_id_ready", 32'(pipe.id_ready), 32'h1);
        step();
        check("flush_ex_valid", 32'(pipe.ex_valid), 32'h0);
        check("flush_ex_pc_held", pipe.ex_pc, 32'h500);
        mem_we = 1'b1; mem_rd = 5'd1; mem_fwd_valid = 1'b0;
        #1;
        check("flush_haz_id_ready", 32'(pipe.id_ready), 32'h1);
        step();
        check("flush_haz_ex_valid", 32'(pipe.ex_valid), 32'h0);
        check("flush_haz_stall_cnt", 32'(stall_cnt), 32'h5);
        flush = 1'b0;

        // Reset while EX is stalled and flush is raised
        mem_we = 1'b0; mem_fwd_valid = 1'b1; pipe.id_pc = 32'h700;
        step();
        check("pre_rst_ex_valid", 32'(pipe.ex_valid), 32'h1);
        pipe.ex_ready = 1'b0; flush = 1'b1; rstn = 1'b0;
        #1;
        check("midrst_id_ready", 32'(pipe.id_ready), 32'h0);
        step();
        check("midrst_ex_valid", 32'(pipe.ex_valid), 32'h0);
        check("midrst_ex_pc", pipe.ex_pc, 32'h0);
        check("midrst_stall_cnt", 32'(stall_cnt), 32'h0);
        flush = 1'b0; pipe.ex_ready = 1'b1; rstn = 1'b1;

        // Counter saturation with a 4-bit counter
        pipe.id_rs1 = 5'd1; pipe.id_rs1_en = 1'b1;
        mem_we = 1'b1; mem_rd = 5'd1; mem_fwd_valid = 1'b0;
        repeat (14) step();
        check("sat_cnt_14", 32'(stall_cnt), 32'he);
        repeat (6) step();
        check("sat_cnt_20", 32'(stall_cnt), 32'hf);
        check("sat_ex_valid", 32'(pipe.ex_valid), 32'h0);
        rstn = 1'b0;
        step();
        check("sat_rst_cnt", 32'(stall_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
